// File: rtl/usb_rx_rcu.sv
// usb_rx_rcu: receive control unit for the USB full-speed RX path.
// Checks the SYNC byte, strobes one FIFO write per data byte, and separates
// clean end-of-packet from errors. r_error stays set until the next packet
// starts.
// Optional feature macro: USB_RX_RCU_BYTE_CNT_EN adds the byte_cnt output, a
// saturating count of the data bytes written in the current packet.
module usb_rx_rcu #(
  parameter int                 DATA_W    = 8,
  parameter logic [DATA_W-1:0]  SYNC_BYTE = 'h80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_edge,
  input  logic              eop,
  input  logic              shift_enable,
  input  logic              byte_received,
  input  logic [DATA_W-1:0] rcv_data,
  output logic              rcving,
  output logic              w_enable,
`ifdef USB_RX_RCU_BYTE_CNT_EN
  output logic [7:0]        byte_cnt,
`endif
  output logic              r_error
);

  typedef enum logic [3:0] {
    IDLE, START, CHK_SYNC, RCV_BITS, STORE, BYTE_DONE,
    EOP_WAIT, ERR_WAIT, ERR_EOP, EIDLE
  } state_t;

  state_t state, nxt;

  // Next-state selection; outputs are registered from it so they always
  // reflect the state register and never follow an input combinationally.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (d_edge) nxt = START;
      START:     if (byte_received) nxt = CHK_SYNC;
      CHK_SYNC:  nxt = (rcv_data == SYNC_BYTE) ? RCV_BITS : ERR_WAIT;
      // A completed byte wins over a same-cycle EOP sample.
      RCV_BITS:  if (byte_received) nxt = STORE;
                 else if (shift_enable && eop) nxt = ERR_WAIT;
      STORE:     nxt = BYTE_DONE;
      BYTE_DONE: if (shift_enable) nxt = eop ? EOP_WAIT : RCV_BITS;
      EOP_WAIT:  if (d_edge) nxt = IDLE;
      ERR_WAIT:  if (shift_enable && eop) nxt = ERR_EOP;
      ERR_EOP:   if (d_edge) nxt = EIDLE;
      EIDLE:     if (d_edge) nxt = START;
      default:   nxt = IDLE;
    endcase
  end

  // State register and Moore outputs decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rcving   <= 1'b0;
      w_enable <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      state    <= nxt;
      rcving   <= (nxt != IDLE) && (nxt != EIDLE);
      w_enable <= (nxt == STORE);
      r_error  <= (nxt == ERR_WAIT) || (nxt == ERR_EOP) || (nxt == EIDLE);
    end
  end

`ifdef USB_RX_RCU_BYTE_CNT_EN
  // Bytes stored this packet: cleared at packet start, saturates at 255,
  // and held after EOP so it can be read out between packets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      byte_cnt <= 8'd0;
    else if (nxt == START && state != START)
      byte_cnt <= 8'd0;
    else if (state == STORE && byte_cnt != 8'hFF)
      byte_cnt <= byte_cnt + 8'd1;
  end
`endif

endmodule
